// File: rtl/toggle_period_meter_if.sv
// Bus between the period meter and its environment: the measured signal in,
// the registered measurement results out.
interface toggle_period_meter_if #(
    parameter int N = 8
);
    logic         sig_in;
    logic [N-1:0] half_period;
    logic [N:0]   full_period;
    logic         meas_valid;
    logic         full_valid;
    logic         locked;
    logic         timeout;

    modport master (
        output sig_in,
        input  half_period, full_period, meas_valid, full_valid, locked, timeout
    );

    modport slave (
        input  sig_in,
        output half_period, full_period, meas_valid, full_valid, locked, timeout
    );
endinterface

// File: rtl/toggle_period_meter.sv
// Measures the clk-cycle distance between edges of an asynchronous toggling
// signal, reports half/full period, lock on a stable period and stall timeout.
module toggle_period_meter #(
    parameter int N        = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    toggle_period_meter_if.slave  bus
);
    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [N-1:0] CNT_MAX = {N{1'b1}};
    localparam logic [N-1:0] CNT_ONE = N'(1);
    localparam logic [3:0]   EQ_MAX  = 4'(LOCK_CNT - 1);

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_s1, r_s2, r_s3;
    logic [N-1:0] r_cnt;
    logic [N-1:0] r_half;
    logic [N:0]   r_full;
    logic         r_mv;
    logic         r_fv;
    logic         r_locked;
    logic         r_timeout;
    logic [3:0]   r_eq_run;
    logic         r_first;

    logic         w_edge;
    logic         w_sat;
    logic         w_start;
    logic         w_measure;
    logic         w_tmo;
    logic         w_eq;
    logic [3:0]   w_eq_nxt;

    assign w_edge   = r_s2 ^ r_s3;
    assign w_sat    = (r_cnt == CNT_MAX);
    // The first measurement of a run has no predecessor to compare against.
    assign w_eq     = (r_cnt == r_half) && !r_first;
    assign w_eq_nxt = w_eq ? ((r_eq_run == EQ_MAX) ? r_eq_run : (r_eq_run + 4'd1)) : 4'd0;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; an edge takes precedence over saturation.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_measure   = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_edge) begin
                    w_state_nxt = MEASURE;
                    w_start     = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            MEASURE: begin
                if (w_edge) begin
                    w_measure = 1'b1;
                end else if (w_sat) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = MEASURE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Synchronizer, cycle counter and measurement registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_s3      <= 1'b0;
            r_cnt     <= '0;
            r_half    <= '0;
            r_full    <= '0;
            r_mv      <= 1'b0;
            r_fv      <= 1'b0;
            r_locked  <= 1'b0;
            r_timeout <= 1'b0;
            r_eq_run  <= 4'd0;
            r_first   <= 1'b0;
        end else begin
            r_s1 <= bus.sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            r_mv <= w_measure;
            if (w_edge) begin
                r_cnt <= CNT_ONE;
            end else if (w_sat) begin
                r_cnt <= r_cnt;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
            if (w_start) begin
                r_fv     <= 1'b0;
                r_first  <= 1'b1;
                r_eq_run <= 4'd0;
                r_locked <= 1'b0;
            end else if (w_measure) begin
                r_half    <= r_cnt;
                r_full    <= {1'b0, r_cnt} + {1'b0, r_half};
                r_fv      <= !r_first;
                r_first   <= 1'b0;
                r_eq_run  <= w_eq_nxt;
                r_locked  <= (w_eq_nxt == EQ_MAX);
                r_timeout <= 1'b0;
            end else if (w_tmo) begin
                r_timeout <= 1'b1;
                r_eq_run  <= 4'd0;
                r_locked  <= 1'b0;
                r_fv      <= 1'b0;
            end else begin
                r_eq_run <= r_eq_run;
            end
        end
    end

    assign bus.half_period = r_half;
    assign bus.full_period = r_full;
    assign bus.meas_valid  = r_mv;
    assign bus.full_valid  = r_fv;
    assign bus.locked      = r_locked;
    assign bus.timeout     = r_timeout;
endmodule
